// File: rtl/hb_pkg.sv
// Shared definitions for the heartbeat transmitter: edge-mode encodings and FSM states.
package hb_pkg;

  localparam logic [1:0] EDGE_POS = 2'b01;
  localparam logic [1:0] EDGE_NEG = 2'b10;
  localparam logic [1:0] EDGE_ANY = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SKIP = 2'd2
  } hb_state_t;

  // Level the heartbeat line rests at when no edge or pulse is being driven.
  function automatic logic idle_level(input logic [1:0] edge_mode);
    return (edge_mode == EDGE_NEG);
  endfunction

endpackage

// File: rtl/hb_period_counter.sv
// Period counter for the heartbeat transmitter: clamps the programmed period to
// at least 2 and strobes 'boundary' on the last cycle of each period.
module hb_period_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 run_i,
  input  logic [CNT_WIDTH-1:0] period_i,
  output logic [CNT_WIDTH-1:0] period_eff_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 boundary_o
);

  localparam logic [CNT_WIDTH-1:0] P_MIN = CNT_WIDTH'(2);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    period_eff_o = (period_i < P_MIN) ? P_MIN : period_i;
    boundary_o   = run_i && (cnt_q >= (period_eff_o - 1'b1));
    cnt_d        = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = boundary_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/heartbeat_gen.sv
// Heartbeat transmitter: drives a guaranteed edge (toggle or pulse) on 'hb' every
// programmed period, with optional suppression of N edges for monitor fault injection.
module heartbeat_gen #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned SKIP_WIDTH = 4,
  parameter logic [1:0]  EDGE       = 2'b11,
  parameter int unsigned PULSE_W    = 1,
  parameter int unsigned PERIOD_RST = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [SKIP_WIDTH-1:0] cfg_skip,
  output logic                  hb,
  output logic                  hb_edge,
  output logic                  skip_active
);

  import hb_pkg::*;

  localparam logic                 IDLE_LVL = idle_level(EDGE);
  localparam logic                 TOGGLE   = (EDGE == EDGE_ANY);
  localparam logic [CNT_WIDTH-1:0] PW       = CNT_WIDTH'(PULSE_W);

  hb_state_t             state_q, state_d;
  logic [CNT_WIDTH-1:0]  period_q, period_d;
  logic [CNT_WIDTH-1:0]  sh_period_q, sh_period_d;
  logic [SKIP_WIDTH-1:0] skip_cnt_q, skip_cnt_d;
  logic [SKIP_WIDTH-1:0] sh_skip_q, sh_skip_d;
  logic                  pend_q, pend_d;
  logic                  hb_q, hb_d;
  logic                  hb_edge_q, hb_edge_d;

  logic                  running;
  logic                  accept;
  logic                  boundary;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  period_eff;
  logic [CNT_WIDTH-1:0]  pw;

  assign running = (state_q != IDLE);
  assign accept  = cfg_valid && !pend_q;
  assign pw      = (PW < (period_eff - 1'b1)) ? PW : (period_eff - 1'b1);

  hb_period_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (!running || !en),
    .run_i        (running),
    .period_i     (period_q),
    .period_eff_o (period_eff),
    .cnt_o        (cnt),
    .boundary_o   (boundary)
  );

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    sh_period_d = sh_period_q;
    skip_cnt_d  = skip_cnt_q;
    sh_skip_d   = sh_skip_q;
    pend_d      = pend_q;
    hb_d        = hb_q;
    hb_edge_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          period_d   = cfg_period;
          skip_cnt_d = cfg_skip;
        end
        if (en) begin
          state_d = (skip_cnt_d != '0) ? SKIP : RUN;
        end
      end
      default: begin
        if (!en) begin
          // Leaving: a shadowed or same-cycle config is not lost, it lands in IDLE.
          state_d    = IDLE;
          hb_d       = IDLE_LVL;
          pend_d     = 1'b0;
          skip_cnt_d = '0;
          if (accept) begin
            period_d   = cfg_period;
            skip_cnt_d = cfg_skip;
          end else if (pend_q) begin
            period_d   = sh_period_q;
            skip_cnt_d = sh_skip_q;
          end
        end else begin
          if (!TOGGLE && (hb_q != IDLE_LVL) && (cnt == (pw - 1'b1))) begin
            hb_d = IDLE_LVL;
          end
          if (boundary) begin
            if (skip_cnt_q == '0) begin
              hb_edge_d = 1'b1;
              hb_d      = TOGGLE ? !hb_q : !IDLE_LVL;
            end else begin
              skip_cnt_d = skip_cnt_q - 1'b1;
            end
            if (pend_q) begin
              period_d   = sh_period_q;
              skip_cnt_d = sh_skip_q;
              pend_d     = 1'b0;
            end
          end
          if (accept) begin
            pend_d      = 1'b1;
            sh_period_d = cfg_period;
            sh_skip_d   = cfg_skip;
          end
          state_d = (skip_cnt_d != '0) ? SKIP : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      period_q    <= CNT_WIDTH'(PERIOD_RST);
      sh_period_q <= '0;
      skip_cnt_q  <= '0;
      sh_skip_q   <= '0;
      pend_q      <= 1'b0;
      hb_q        <= IDLE_LVL;
      hb_edge_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      sh_period_q <= sh_period_d;
      skip_cnt_q  <= skip_cnt_d;
      sh_skip_q   <= sh_skip_d;
      pend_q      <= pend_d;
      hb_q        <= hb_d;
      hb_edge_q   <= hb_edge_d;
    end
  end

  assign hb          = hb_q;
  assign hb_edge     = hb_edge_q;
  assign skip_active = (state_q == SKIP);
  assign cfg_ready   = !pend_q;

endmodule

// File: tb/tb_heartbeat_gen.sv
// Bench for heartbeat_gen: three edge modes driven in parallel, checked against an
// event-time reference model (boundary times, edge counts, time since last edge).
module tb_heartbeat_gen;

  logic        clk = 1'b0;
  logic        rst_n, en, cfg_valid;
  logic [15:0] cfg_period;
  logic [3:0]  cfg_skip;

  logic t_ready, t_hb, t_edge, t_skip;
  logic p_ready, p_hb, p_edge, p_skip;
  logic n_ready, n_hb, n_edge, n_skip;
  logic [11:0] obs;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  heartbeat_gen #(.CNT_WIDTH(16), .SKIP_WIDTH(4), .EDGE(2'b11), .PULSE_W(1), .PERIOD_RST(16)) u_tog (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(t_ready),
    .cfg_period(cfg_period), .cfg_skip(cfg_skip), .hb(t_hb), .hb_edge(t_edge), .skip_active(t_skip));

  heartbeat_gen #(.CNT_WIDTH(16), .SKIP_WIDTH(4), .EDGE(2'b01), .PULSE_W(2), .PERIOD_RST(16)) u_pos (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(p_ready),
    .cfg_period(cfg_period), .cfg_skip(cfg_skip), .hb(p_hb), .hb_edge(p_edge), .skip_active(p_skip));

  heartbeat_gen #(.CNT_WIDTH(16), .SKIP_WIDTH(4), .EDGE(2'b10), .PULSE_W(3), .PERIOD_RST(16)) u_neg (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(n_ready),
    .cfg_period(cfg_period), .cfg_skip(cfg_skip), .hb(n_hb), .hb_edge(n_edge), .skip_active(n_skip));

  assign obs = {t_hb, p_hb, n_hb, t_edge, p_edge, n_edge,
                t_ready, p_ready, n_ready, t_skip, p_skip, n_skip};

  // Reference model state: absolute edge index, next boundary time, edge history.
  int m_t = 0;
  bit m_run = 1'b0;
  bit m_pend = 1'b0;
  bit m_edge = 1'b0;
  int m_period = 16, m_skip = 0, m_shp = 0, m_shs = 0;
  int m_nb = 0, m_edges = 0, m_last = -1000, m_pwp = 0, m_pwn = 0;

  function automatic int peff(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [11:0] exp_vec();
    logic hbt, ap, an, rd, sk;
    hbt = (m_edges % 2) != 0;
    ap  = m_run && ((m_t - m_last) < m_pwp);
    an  = m_run && ((m_t - m_last) < m_pwn);
    rd  = !m_pend;
    sk  = m_run && (m_skip != 0);
    return {hbt, ap, !an, {3{m_edge}}, {3{rd}}, {3{sk}}};
  endfunction

  // Advance one clock: update the model with the inputs seen at the edge, then
  // return on the falling edge so DUT outputs are sampled away from posedge.
  task automatic tick();
    bit acc, fire;
    @(posedge clk);
    m_t++;
    m_edge = 1'b0;
    if (!rst_n) begin
      m_run = 1'b0; m_period = 16; m_skip = 0; m_pend = 1'b0;
      m_edges = 0; m_last = -1000;
    end else begin
      acc = cfg_valid && !m_pend;
      if (!m_run) begin
        if (acc) begin m_period = cfg_period; m_skip = cfg_skip; end
        if (en) begin m_run = 1'b1; m_nb = m_t + peff(m_period); end
      end else if (!en) begin
        m_run = 1'b0; m_edges = 0; m_last = -1000;
        if (acc) begin m_period = cfg_period; m_skip = cfg_skip; end
        else if (m_pend) begin m_period = m_shp; m_skip = m_shs; end
        else m_skip = 0;
        m_pend = 1'b0;
      end else begin
        if (m_t == m_nb) begin
          fire = (m_skip == 0);
          if (!fire) m_skip--;
          if (m_pend) begin m_period = m_shp; m_skip = m_shs; m_pend = 1'b0; end
          if (fire) begin
            m_edge = 1'b1; m_edges++; m_last = m_t;
            m_pwp = imin(2, peff(m_period) - 1);
            m_pwn = imin(3, peff(m_period) - 1);
          end
          m_nb = m_t + peff(m_period);
        end
        if (acc) begin m_pend = 1'b1; m_shp = cfg_period; m_shs = cfg_skip; end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; cfg_valid = 1'b0; cfg_period = 16'd4; cfg_skip = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++; $display("FAIL reset_model t=%0d got=%b exp=%b", m_t, obs, exp_vec());
      end
      tests_run++;
      if ({t_hb, t_edge, t_ready, n_hb} !== 4'b0011) begin
        tests_failed++; $display("FAIL reset_values t=%0d got=%b exp=0011", m_t, {t_hb, t_edge, t_ready, n_hb});
      end
    end
    rst_n = 1'b1; en = 1'b0;
    tick();
    tests_run++;
    if (obs !== exp_vec()) begin
      tests_failed++; $display("FAIL reset_release t=%0d got=%b exp=%b", m_t, obs, exp_vec());
    end
  endtask

  task automatic test_toggle();
    logic eh, ee;
    cfg_valid = 1'b1; cfg_period = 16'd4; cfg_skip = 4'd0;
    tick();
    cfg_valid = 1'b0; en = 1'b1;
    tick();
    for (int i = 1; i <= 13; i++) begin
      tick();
      ee = (i % 4) == 0;
      eh = ((i / 4) % 2) != 0;
      tests_run++;
      if ({t_hb, t_edge} !== {eh, ee} || obs !== exp_vec()) begin
        tests_failed++;
        $display("FAIL toggle i=%0d got hb/edge=%b%b exp=%b%b all=%b model=%b", i, t_hb, t_edge, eh, ee, obs, exp_vec());
      end
    end
  endtask

  task automatic test_pulse();
    logic ep, en_lvl;
    en = 1'b0;
    tick();
    cfg_valid = 1'b1; cfg_period = 16'd5;
    tick();
    cfg_valid = 1'b0; en = 1'b1;
    tick();
    for (int i = 1; i <= 16; i++) begin
      tick();
      ep     = (i >= 5) && ((i % 5) < 2);
      en_lvl = !((i >= 5) && ((i % 5) < 3));
      tests_run++;
      if ({p_hb, n_hb} !== {ep, en_lvl} || obs !== exp_vec()) begin
        tests_failed++;
        $display("FAIL pulse i=%0d got pos/neg=%b%b exp=%b%b all=%b model=%b", i, p_hb, n_hb, ep, en_lvl, obs, exp_vec());
      end
    end
  endtask

  task automatic test_skip();
    int e0, e1;
    bit saw_skip;
    e0 = -1; e1 = -1; saw_skip = 1'b0;
    en = 1'b0;
    tick();
    cfg_valid = 1'b1; cfg_period = 16'd4; cfg_skip = 4'd0;
    tick();
    cfg_valid = 1'b0; en = 1'b1;
    tick();
    cfg_valid = 1'b1; cfg_period = 16'd4; cfg_skip = 4'd3;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (t_edge === 1'b1) begin
        if (e0 < 0) e0 = m_t;
        else if (e1 < 0) e1 = m_t;
      end
      if (t_skip === 1'b1) saw_skip = 1'b1;
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++; $display("FAIL skip_model t=%0d got=%b exp=%b", m_t, obs, exp_vec());
      end
    end
    tests_run++;
    if ((e1 - e0) != 16 || e0 < 0 || e1 < 0) begin
      tests_failed++; $display("FAIL skip_gap got=%0d exp=16", e1 - e0);
    end
    tests_run++;
    if (!saw_skip) begin
      tests_failed++; $display("FAIL skip_active got=0 exp=1");
    end
  endtask

  task automatic test_cfg_boundary();
    logic ee, er, en_lvl;
    for (int g = 0; g < 10 && (m_t + 1) != m_nb; g++) tick();
    cfg_valid = 1'b1; cfg_period = 16'd8; cfg_skip = 4'd0;
    tick();
    cfg_valid = 1'b0;
    tests_run++;
    if ({t_edge, t_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL cfg_on_boundary got edge/ready=%b exp=10", {t_edge, t_ready});
    end
    for (int i = 1; i <= 14; i++) begin
      tick();
      ee = (i == 4) || (i == 12);
      er = (i >= 4);
      tests_run++;
      if ({t_edge, t_ready} !== {ee, er} || obs !== exp_vec()) begin
        tests_failed++;
        $display("FAIL cfg_apply i=%0d got edge/ready=%b%b exp=%b%b", i, t_edge, t_ready, ee, er);
      end
    end
    for (int p = 0; p < 2; p++) begin
      en = 1'b0; cfg_valid = 1'b1; cfg_period = 16'(p);
      tick();
      cfg_valid = 1'b0; en = 1'b1;
      tick();
      for (int i = 1; i <= 6; i++) begin
        tick();
        ee     = (i % 2) == 0;
        en_lvl = !ee;
        tests_run++;
        if ({t_edge, n_hb} !== {ee, en_lvl} || obs !== exp_vec()) begin
          tests_failed++;
          $display("FAIL clamp p=%0d i=%0d got edge/neg=%b%b exp=%b%b", p, i, t_edge, n_hb, ee, en_lvl);
        end
      end
    end
  endtask

  task automatic test_en_drop();
    logic ee;
    bit found;
    en = 1'b0;
    tick();
    cfg_valid = 1'b1; cfg_period = 16'd6; cfg_skip = 4'd0;
    tick();
    cfg_valid = 1'b0; en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    tests_run++;
    if (t_hb !== 1'b1) begin
      tests_failed++; $display("FAIL drop_pre hb got=%b exp=1", t_hb);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({t_hb, t_edge, n_hb, t_skip} !== 4'b0010 || obs !== exp_vec()) begin
        tests_failed++; $display("FAIL drop_idle i=%0d got=%b exp=0010", i, {t_hb, t_edge, n_hb, t_skip});
      end
    end
    en = 1'b1;
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      ee = (i == 6);
      tests_run++;
      if (t_edge !== ee || obs !== exp_vec()) begin
        tests_failed++; $display("FAIL reenable i=%0d got edge=%b exp=%b", i, t_edge, ee);
      end
    end
    cfg_valid = 1'b1; cfg_period = 16'd4; cfg_skip = 4'd5;
    tick();
    cfg_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (t_skip === 1'b1) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++; $display("FAIL skip_entry got skip_active=0 exp=1 within 12 cycles");
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if ({t_hb, t_edge, t_ready, t_skip, n_hb} !== 5'b00101 || obs !== exp_vec()) begin
      tests_failed++; $display("FAIL reset_in_skip got=%b exp=00101", {t_hb, t_edge, t_ready, t_skip, n_hb});
    end
    rst_n = 1'b1; en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    for (int i = 1; i <= 17; i++) begin
      tick();
      ee = (i == 16);
      tests_run++;
      if (t_edge !== ee || obs !== exp_vec()) begin
        tests_failed++; $display("FAIL period_rst i=%0d got edge=%b exp=%b", i, t_edge, ee);
      end
    end
  endtask

  task automatic test_random();
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      cfg_valid  = ($urandom_range(0, 7) == 0);
      cfg_period = 16'($urandom_range(0, 9));
      cfg_skip   = 4'($urandom_range(0, 3));
      tick();
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++; $display("FAIL random t=%0d got=%b exp=%b", m_t, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_skip = '0;
    test_reset();
    test_toggle();
    test_pulse();
    test_skip();
    test_cfg_boundary();
    test_en_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
